ir_issue_queue: RTL

Instruction encode-and-issue queue that feeds the AL execution core. It accepts decoded instruction fields from a control or sequencer source through a valid/ready handshake. It packs the fields into the 32-bit IR format, screens out illegal opcodes, and buffers legal words in a small FIFO. It then presents them to the core's IR input through a second valid/ready handshake.

---
 rtl/ir_issue_queue.sv | 117 +++++++++++
 1 files changed

// File: rtl/ir_issue_queue.sv
// Instruction encode-and-issue queue: packs decoded fields into 32-bit IR words,
// drops illegal opcodes, and buffers legal words in a FIFO for the execution core.
module ir_issue_queue #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned AW    = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic [4:0]    req_oper,
   input  logic [4:0]    req_rdst,
   input  logic [4:0]    req_rsrc1,
   input  logic          req_imm_mode,
   input  logic [4:0]    req_rsrc2,
   input  logic [15:0]   req_isrc,
   output logic          ir_valid,
   input  logic          ir_ready,
   output logic [31:0]   ir_out,
   output logic          illegal,
   output logic [AW:0]   count,
   output logic [15:0]   issued_cnt,
   output logic [7:0]    err_cnt
);

   localparam logic [AW:0] FullCount = (AW+1)'(DEPTH);
   localparam logic [4:0]  NumLegal  = 5'd12;

   logic [31:0]   mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic [15:0]   issued_q, issued_d;
   logic [7:0]    err_q, err_d;
   logic          illegal_q, illegal_d;

   logic          legal;
   logic          push;
   logic          pop;
   logic          wr_en;
   logic [31:0]   enc_word;

   assign enc_word = {req_oper, req_rdst, req_rsrc1, req_imm_mode,
                      req_imm_mode ? req_isrc : {req_rsrc2, 11'd0}};
   assign legal    = req_oper < NumLegal;

   assign req_ready  = (count_q < FullCount) && !rst;
   assign ir_valid   = (count_q != '0);
   assign ir_out     = ir_valid ? mem_q[rd_ptr_q] : 32'h0;
   assign illegal    = illegal_q;
   assign count      = count_q;
   assign issued_cnt = issued_q;
   assign err_cnt    = err_q;

   // Flush suppresses both handshakes so no counter moves in that cycle.
   assign push  = req_valid && req_ready && !flush;
   assign pop   = ir_valid && ir_ready && !flush;
   assign wr_en = push && legal;

   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      issued_d  = issued_q;
      err_d     = err_q;
      illegal_d = 1'b0;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (wr_en) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
         end
         if (push && !legal) begin
            illegal_d = 1'b1;
            err_d     = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            issued_d = issued_q + 16'd1;
         end
         unique case ({wr_en, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         issued_q  <= '0;
         err_q     <= '0;
         illegal_q <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         issued_q  <= issued_d;
         err_q     <= err_d;
         illegal_q <= illegal_d;
      end
   end

   // Storage needs no reset: ir_out is masked whenever the queue is empty.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_ptr_q] <= enc_word;
      end
   end

endmodule
